// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId state, interrupt/exception
// arbitration, the one-cycle Req flush pulse and the mfc0/mtc0/eret interface.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h2021_0608
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC,
    input  logic        M_DelaySlot,
    input  logic [4:0]  M_EXCCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] HandlerPC,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        mtc0_sr;
    logic        mtc0_epc;
    logic [31:0] epc_target;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // EXL masks everything, so Req can never last longer than the edge that sets EXL.
    always_comb begin
        int_req  = sr_ie_q & ~sr_exl_q & (|(HWInt & sr_im_q));
        exc_req  = ~sr_exl_q & (M_EXCCode != 5'd0);
        req      = int_req | exc_req;
        mtc0_sr  = WE & ~req & (A2 == REG_SR);
        mtc0_epc = WE & ~req & (A2 == REG_EPC);
    end

    always_comb begin
        epc_target = M_DelaySlot ? (M_PC - 32'd4) : M_PC;
        epc_target = {epc_target[31:2], 2'b00};
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block leaves one unassigned and infers a latch.
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (mtc0_sr) begin
            sr_im_d  = DIn[15:10];
            sr_exl_d = DIn[1];
            sr_ie_d  = DIn[0];
        end
        if (mtc0_epc) begin
            epc_d = DIn;
        end
        // eret overrides a simultaneous mtc0 for the EXL bit only.
        if (EXLClr) begin
            sr_exl_d = 1'b0;
        end

        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = M_DelaySlot;
            cause_exc_d = int_req ? 5'd0 : M_EXCCode;
            epc_d       = epc_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state flops take non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
        cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

    assign Req       = req;
    assign HandlerPC = HANDLER_ADDR;
    assign EPCOut    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios then random traffic; a word-level
// model feeds a scoreboard queue drained by a negedge monitor.
module tb_cp0_unit;

    typedef struct packed {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  A1 = 5'd0;
    logic [4:0]  A2 = 5'd0;
    logic [31:0] DIn = 32'd0;
    logic        WE = 1'b0;
    logic [31:0] M_PC = 32'd0;
    logic        M_DelaySlot = 1'b0;
    logic [4:0]  M_EXCCode = 5'd0;
    logic [5:0]  HWInt = 6'h3F;
    logic        EXLClr = 1'b0;
    logic        Req;
    logic [31:0] HandlerPC;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    // Reference state kept as whole architectural register words.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .M_PC(M_PC), .M_DelaySlot(M_DelaySlot), .M_EXCCode(M_EXCCode),
        .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req), .HandlerPC(HandlerPC),
        .EPCOut(EPCOut), .DOut(DOut)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_int();
        return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic model_req();
        return model_int() || (!m_sr[1] && M_EXCCode != 5'd0);
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.req = model_req();
        e.epc = m_epc;
        case (A1)
            5'd12:   e.dout = m_sr;
            5'd13:   e.dout = m_cause;
            5'd14:   e.dout = m_epc;
            5'd15:   e.dout = 32'h2021_0608;
            default: e.dout = 32'd0;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        m_sr = 32'd0;
        m_cause = 32'd0;
        m_epc = 32'd0;
    endtask

    task automatic model_update();
        logic taken, by_int;
        if (reset) begin
            model_reset();
            return;
        end
        taken  = model_req();
        by_int = model_int();
        if (taken) begin
            m_sr[1] = 1'b1;
            m_cause[31] = M_DelaySlot;
            m_cause[6:2] = by_int ? 5'd0 : M_EXCCode;
            m_epc = (M_DelaySlot ? M_PC - 32'd4 : M_PC) & 32'hFFFF_FFFC;
        end else begin
            if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
            if (WE && A2 == 5'd14) m_epc = DIn;
            if (EXLClr) m_sr[1] = 1'b0;
        end
        m_cause[15:10] = HWInt;
    endtask

    // Inputs are set at posedge+1; queue this cycle's expectation, cross the edge.
    task automatic step();
        sb.push_back(model_expect());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic probe(input logic [4:0] a1, input logic [31:0] exp, input string name);
        A1 = a1;
        #1;
        check(name, DOut, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_req", {31'd0, Req}, {31'd0, e.req});
                check("sb_dout", DOut, e.dout);
                check("sb_epcout", EPCOut, e.epc);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        // Reset state with all interrupt lines high.
        check("rst_req", {31'd0, Req}, 32'd0);
        probe(5'd12, 32'd0, "rst_sr");
        probe(5'd13, 32'd0, "rst_cause");
        probe(5'd14, 32'd0, "rst_epc");
        probe(5'd15, 32'h2021_0608, "rst_prid");
        check("handler_pc", HandlerPC, 32'h0000_4180);
        step();
        reset = 1'b0;
        HWInt = 6'd0;
        step();

        // Enable IM[10] and IE, then raise HWInt[0].
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        step();
        WE = 1'b0; HWInt = 6'b000001; M_PC = 32'h3010; A1 = 5'd12;
        #1 check("int_req", {31'd0, Req}, 32'd1);
        step();
        HWInt = 6'd0;
        #1 check("int_req_pulse", {31'd0, Req}, 32'd0);
        probe(5'd12, 32'h0000_0403, "int_sr");
        probe(5'd13, 32'h0000_0400, "int_cause");
        probe(5'd14, 32'h0000_3010, "int_epc");
        step();
        EXLClr = 1'b1;
        step();

        // AdEL in a delay slot.
        EXLClr = 1'b0;
        probe(5'd12, 32'h0000_0401, "eret_sr");
        M_EXCCode = 5'd4; M_DelaySlot = 1'b1; M_PC = 32'h3008;
        #1 check("exc_req", {31'd0, Req}, 32'd1);
        step();
        M_EXCCode = 5'd0; M_DelaySlot = 1'b0;
        probe(5'd13, 32'h8000_0010, "exc_cause");
        probe(5'd14, 32'h0000_3004, "exc_epc");
        EXLClr = 1'b1;
        step();

        // Exception and interrupt together, with an mtc0 EPC that must be dropped.
        EXLClr = 1'b0;
        M_EXCCode = 5'd10; HWInt = 6'b000001; M_PC = 32'h3020;
        WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
        #1 check("prio_req", {31'd0, Req}, 32'd1);
        step();
        WE = 1'b0; M_EXCCode = 5'd0;
        probe(5'd13, 32'h0000_0400, "prio_cause");
        probe(5'd14, 32'h0000_3020, "prio_epc");

        // Masked while EXL=1, then eret re-exposes the pending interrupt.
        M_EXCCode = 5'd12;
        #1 check("exl_mask_req", {31'd0, Req}, 32'd0);
        step();
        M_EXCCode = 5'd0; EXLClr = 1'b1;
        #1 check("eret_cycle_req", {31'd0, Req}, 32'd0);
        step();
        EXLClr = 1'b0; M_PC = 32'h3010;
        probe(5'd12, 32'h0000_0401, "post_eret_sr");
        check("post_eret_req", {31'd0, Req}, 32'd1);
        step();

        // Async reset mid-cycle while inside the handler.
        HWInt = 6'd0;
        probe(5'd14, 32'h0000_3010, "pre_rst_epc");
        probe(5'd12, 32'h0000_0403, "pre_rst_sr");
        reset = 1'b1;
        model_reset();
        probe(5'd12, 32'd0, "async_rst_sr");
        probe(5'd13, 32'd0, "async_rst_cause");
        probe(5'd14, 32'd0, "async_rst_epc");
        step();
        reset = 1'b0;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            M_EXCCode   = (!reset && $urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt       = 6'($urandom);
            M_PC        = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            M_DelaySlot = 1'($urandom);
            WE          = ($urandom_range(0, 2) == 0);
            A2          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            DIn         = $urandom;
            A1          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            EXLClr      = m_sr[1] && ($urandom_range(0, 3) == 0);
            if (reset) model_reset();
            step();
        end
        reset = 1'b0; WE = 1'b0; EXLClr = 1'b0; M_EXCCode = 5'd0;

        repeat (3) @(posedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt controller in the M stage of the 5-stage MIPS pipeline.
- Owns SR (reg 12), Cause (reg 13), EPC (reg 14) and PRId (reg 15).
- Arbitrates pipeline exception codes against external hardware interrupts.
- Drives the single-cycle Req pulse that every pipeline register consumes to flush and redirect to the handler.
- Serves mfc0/mtc0/eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, handler entry PC presented with Req.
- PRID_VAL, 32'h2021_0608, constant value read from reg 15.

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all CP0 state immediately
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- DIn  in  32  mtc0 write data
- WE  in  1  mtc0 write enable
- M_PC  in  32  PC of instruction currently in M
- M_DelaySlot  in  1  M instruction sits in a branch delay slot
- M_EXCCode  in  5  pipeline exception code accumulated through F/D/E/M; 0 = none
- HWInt  in  6  external interrupt lines, level-sensitive
- EXLClr  in  1  eret in M
- Req  out  1  exception/interrupt taken this cycle (combinational)
- HandlerPC  out  32  constant HANDLER_ADDR
- EPCOut  out  32  current EPC, for eret redirect
- DOut  out  32  mfc0 read data (combinational)

Behaviour:
- Field layout:
  - SR: IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC: 32 bits.
- Reset (async): SR=0, Cause=0, EPC=0.
  - Req=0 after reset, since IE=0 and M_EXCCode is expected 0 while pipeline regs are reset.
  - Reset asserted mid-handler drops EXL immediately.
- Request logic (combinational on current state):
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (M_EXCCode != 0).
  - Req = IntReq | ExcReq.
  - Req is guaranteed a one-cycle pulse: EXL sets on the same edge.
- On posedge with Req=1:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : M_EXCCode. Interrupt has priority over a simultaneous exception.
  - Cause.BD <= M_DelaySlot.
  - EPC <= M_DelaySlot ? (M_PC - 4) : M_PC, with bits [1:0] forced to 0.
  - The mtc0 in the same cycle is discarded: the faulting instruction does not commit.
- Cause.IP <= HWInt on every posedge regardless of Req/EXL. IP reflects one-cycle-delayed HWInt.
- mtc0 (WE=1 & Req=0) on posedge:
  - A2=12: SR.IM/EXL/IE <= DIn fields; other bits ignored.
  - A2=14: EPC <= DIn.
  - A2=13, 15, or any other: no effect.
- EXLClr=1 on posedge: EXL <= 0.
  - Req cannot coincide with EXLClr, since Req requires EXL=0 and eret runs with EXL=1.
  - If both EXLClr and mtc0-to-SR occur, EXLClr wins for the EXL bit.
- While EXL=1, all interrupts and exceptions are masked. A nonzero M_EXCCode under EXL=1 is ignored and the state is unchanged.
- DOut mapping:
  - A1=12 → SR
  - 13 → Cause
  - 14 → EPC
  - 15 → PRID_VAL
  - else → 0
  - Read returns pre-edge state: no same-cycle write-through.
- Arithmetic: EPC subtraction is 32-bit modulo. M_PC=0 in a delay slot wraps to 32'hFFFF_FFFC.

Test Plan:
- Reset with HWInt=6'h3F, M_EXCCode=0 → Req=0; DOut=0 for A1=12/13/14; DOut=32'h2021_0608 for A1=15.
- mtc0 SR←32'h0000_0401 (IM[10], IE), then HWInt=6'b000001, M_PC=32'h3010 → Req=1 for exactly one cycle; next cycle SR=32'h0000_0403, Cause.ExcCode=0, EPC=32'h3010.
- M_EXCCode=5'd4 (AdEL), M_DelaySlot=1, M_PC=32'h3008, EXL=0 → Req=1; Cause=32'h8000_0010 (IP=0), EPC=32'h3004.
- Exception and enabled interrupt in the same cycle (M_EXCCode=5'd10, HWInt[0]=1, IM[10]=IE=1), plus WE=1 to EPC with 32'hDEAD_BEEF → ExcCode=0, EPC=M_PC, DEAD_BEEF write dropped.
- With EXL=1, assert M_EXCCode=5'd12 and HWInt[0] → Req stays 0; then EXLClr=1 → EXL=0 next cycle, Req=1 the cycle after because HWInt is still high.
- Assert reset asynchronously mid-cycle while EXL=1 and EPC=32'h3010 → SR/Cause/EPC read 0 before the next clk edge.
